// File: rtl/perf_cnt_pkg.sv
// Shared constants for the performance counter bank: well-known channel
// indices, default counter width and the snapshot FSM encoding.
package perf_cnt_pkg;

  localparam int CH_CYCLE  = 0;
  localparam int CH_JMP    = 1;
  localparam int CH_BSUC   = 2;
  localparam int CH_BUBBLE = 3;

  localparam int CNT_W_DEF = 32;

  typedef enum logic {
    SNAP_IDLE    = 1'b0,
    SNAP_CAPTURE = 1'b1
  } snap_state_e;

endpackage

// File: rtl/perf_cnt_cell.sv
// One event counter: qualified increment, wrap or saturate at all-ones,
// sticky overflow flag. Exposes its next value so the bank can snapshot it.
module perf_cnt_cell #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             ev,
  input  logic             qual,
  input  logic             freeze,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic inc;
  logic ovf_next;

  function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return SATURATE ? CNT_MAX : '0;
    end
    return v + CNT_W'(1);
  endfunction

  always_comb begin
    inc      = ev & qual & ~freeze;
    cnt_next = cnt;
    ovf_next = ovf;
    if (clear) begin
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (inc) begin
      cnt_next = step_cnt(cnt);
      if (cnt == CNT_MAX) begin
        ovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Event-statistics bank: NUM_CH counters, atomic snapshot handshake and a
// registered read-out mux. Define PERF_CNT_OVF_IRQ_EN for the masked overflow irq.
module perf_counter_bank
  import perf_cnt_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = CNT_W_DEF,
  parameter bit          SATURATE     = 1'b0,
  parameter logic [15:0] PC_QUAL_MASK = 16'h0006,
  localparam int         SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pc_enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ev,
  input  logic              freeze,
  input  logic              snap_req,
  output logic              snap_ack,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_src,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
`ifdef PERF_CNT_OVF_IRQ_EN
  input  logic [NUM_CH-1:0] irq_mask,
`endif
  output logic              irq
);

  snap_state_e state;
  snap_state_e state_next;
  logic        capture;

  logic [CNT_W-1:0] live      [NUM_CH];
  logic [CNT_W-1:0] live_next [NUM_CH];
  logic [CNT_W-1:0] shadow    [NUM_CH];
  logic [CNT_W-1:0] rd_mux_p0;

  // Counter cells; the mask picks which qualifier gates each channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cell
    perf_cnt_cell #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .ev      (ev[i]),
      .qual    (PC_QUAL_MASK[i] ? pc_enable : enable),
      .freeze  (freeze),
      .cnt     (live[i]),
      .cnt_next(live_next[i]),
      .ovf     (ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SNAP_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Requests seen while capturing are dropped, so a held req re-arms every 2 cycles.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      SNAP_IDLE: begin
        if (snap_req) begin
          state_next = SNAP_CAPTURE;
        end
      end
      SNAP_CAPTURE: begin
        capture    = 1'b1;
        state_next = SNAP_IDLE;
      end
      default: state_next = SNAP_IDLE;
    endcase
  end

  // Shadows take the post-increment (or post-clear) value on one shared edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        shadow[i] <= '0;
      end else if (capture) begin
        shadow[i] <= live_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_ack <= 1'b0;
    end else begin
      snap_ack <= capture;
    end
  end

  always_comb begin
    rd_mux_p0 = '0;
    if (int'(rd_sel) < NUM_CH) begin
      rd_mux_p0 = rd_src ? shadow[rd_sel] : live[rd_sel];
    end
  end

  // Read-out register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_mux_p0;
    end
  end

`ifdef PERF_CNT_OVF_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      irq <= 1'b0;
    end else begin
      irq <= |(ovf & irq_mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomised and directed stimulus for two bank instances (wrapping 4-channel,
// saturating 3-channel), checked by a queue-based scoreboard against a reference model.
module tb_perf_counter_bank;

  localparam int W    = 8;
  localparam int MAXC = 255;

  logic       clk = 1'b0;
  logic       rst, enable, pc_enable, clear, freeze, snap_req, rd_src;
  logic [3:0] ev;
  logic [1:0] rd_sel;

  logic         snap_ack_w, snap_ack_s, irq_w, irq_s;
  logic [W-1:0] rd_data_w, rd_data_s;
  logic [3:0]   ovf_w;
  logic [2:0]   ovf_s;

  always #5 clk = ~clk;

  perf_counter_bank #(
    .NUM_CH(4), .CNT_W(W), .SATURATE(1'b0), .PC_QUAL_MASK(16'h0006)
  ) dut_w (
    .clk(clk), .rst(rst), .enable(enable), .pc_enable(pc_enable), .clear(clear),
    .ev(ev), .freeze(freeze), .snap_req(snap_req), .snap_ack(snap_ack_w),
    .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(rd_data_w), .ovf(ovf_w),
`ifdef PERF_CNT_OVF_IRQ_EN
    .irq_mask(4'b0001),
`endif
    .irq(irq_w)
  );

  perf_counter_bank #(
    .NUM_CH(3), .CNT_W(W), .SATURATE(1'b1), .PC_QUAL_MASK(16'h0006)
  ) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .pc_enable(pc_enable), .clear(clear),
    .ev(ev[2:0]), .freeze(freeze), .snap_req(snap_req), .snap_ack(snap_ack_s),
    .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(rd_data_s), .ovf(ovf_s),
`ifdef PERF_CNT_OVF_IRQ_EN
    .irq_mask(3'b001),
`endif
    .irq(irq_s)
  );

  typedef struct {
    int         due;
    int         rd_w;
    int         rd_s;
    bit         ack;
    logic [3:0] ovf_w;
    logic [2:0] ovf_s;
    bit         irq_w;
    bit         irq_s;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: counts as plain integers per instance/channel.
  int  m_live   [2][4];
  int  m_shadow [2][4];
  bit  m_ovf    [2][4];
  bit  m_irq    [2];
  bit  m_cap_pending;
  int  nch      [2] = '{4, 3};
  logic [15:0] qmask = 16'h0006;
  logic [3:0]  imask [2] = '{4'b0001, 4'b0001};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  // Predict all outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    exp_t e;
    bit   captured;
    bit   any;
    int   rdv[2];
    e.due = cyc + 1;
    captured = m_cap_pending && !rst;
    for (int k = 0; k < 2; k++) begin
      rdv[k] = 0;
      if (!rst && int'(rd_sel) < nch[k])
        rdv[k] = rd_src ? m_shadow[k][rd_sel] : m_live[k][rd_sel];
      any = 1'b0;
      for (int i = 0; i < nch[k]; i++)
        if (m_ovf[k][i] && imask[k][i]) any = 1'b1;
`ifdef PERF_CNT_OVF_IRQ_EN
      m_irq[k] = !rst && !clear && any;
`else
      m_irq[k] = 1'b0;
`endif
      for (int i = 0; i < nch[k]; i++) begin
        if (rst || clear) begin
          m_live[k][i] = 0;
          m_ovf[k][i]  = 1'b0;
        end else if (ev[i] && !freeze && (qmask[i] ? pc_enable : enable)) begin
          if (m_live[k][i] == MAXC) begin
            m_live[k][i] = (k == 1) ? MAXC : 0;
            m_ovf[k][i]  = 1'b1;
          end else begin
            m_live[k][i] = m_live[k][i] + 1;
          end
        end
        if (rst) m_shadow[k][i] = 0;
        else if (captured) m_shadow[k][i] = m_live[k][i];
      end
    end
    m_cap_pending = !rst && !m_cap_pending && snap_req;
    e.rd_w  = rdv[0];
    e.rd_s  = rdv[1];
    e.ack   = captured;
    e.irq_w = m_irq[0];
    e.irq_s = m_irq[1];
    for (int i = 0; i < 4; i++) e.ovf_w[i] = m_ovf[0][i];
    for (int i = 0; i < 3; i++) e.ovf_s[i] = m_ovf[1][i];
    sb.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input bit src);
    ev = 4'b0000;
    rd_src = src;
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      tick();
    end
  endtask

  // Monitor: compare whatever the DUT shows against entries that have come due.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rd_data_wrap", 32'(rd_data_w), 32'(e.rd_w));
      chk("rd_data_sat",  32'(rd_data_s), 32'(e.rd_s));
      chk("snap_ack_wrap", 32'(snap_ack_w), 32'(e.ack));
      chk("snap_ack_sat",  32'(snap_ack_s), 32'(e.ack));
      chk("ovf_wrap", 32'(ovf_w), 32'(e.ovf_w));
      chk("ovf_sat",  32'(ovf_s), 32'(e.ovf_s));
      chk("irq_wrap", 32'(irq_w), 32'(e.irq_w));
      chk("irq_sat",  32'(irq_s), 32'(e.irq_s));
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_irq[k] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_live[k][i] = 0; m_shadow[k][i] = 0; m_ovf[k][i] = 1'b0;
      end
    end
    m_cap_pending = 1'b0;
    rst = 1'b1; enable = 1'b0; pc_enable = 1'b0; clear = 1'b0; freeze = 1'b0;
    snap_req = 1'b0; rd_src = 1'b0; ev = 4'b0000; rd_sel = 2'd0;
    tick(); tick();
    rst = 1'b0;

    // Qualifier routing: only enable-qualified channels count.
    enable = 1'b1; pc_enable = 1'b0; ev = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      rd_sel = 2'(i % 4);
      tick();
    end
    read_all(1'b0);

    // Freeze for 5 of 12 event cycles, then snapshot, then clear.
    for (int i = 0; i < 12; i++) begin
      ev = 4'b1111; freeze = (i < 5);
      tick();
    end
    freeze = 1'b0;
    read_all(1'b0);
    snap_req = 1'b1; tick(); snap_req = 1'b0; tick(); tick();
    clear = 1'b1; tick(); clear = 1'b0;
    read_all(1'b0);
    read_all(1'b1);

    // Wrap / saturate: 257 events on every channel.
    pc_enable = 1'b1;
    ev = 4'b1111;
    for (int i = 0; i < 257; i++) begin
      rd_sel = 2'(i % 4); rd_src = 1'b0;
      tick();
    end
    read_all(1'b0);
    clear = 1'b1; tick(); clear = 1'b0;

    // Snapshot under continuous events, then watch the shadow stay put.
    ev = 4'b1111;
    for (int i = 0; i < 20; i++) tick();
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rd_sel = 2'(i % 4); rd_src = i[0];
      tick();
    end
    snap_req = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    snap_req = 1'b0;

    // Reset landing on the capture edge.
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd_sel = 2'(i % 4); rd_src = i[0];
      tick();
    end

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      clear     = ($urandom_range(0, 79) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      pc_enable = ($urandom_range(0, 2) != 0);
      freeze    = ($urandom_range(0, 5) == 0);
      snap_req  = ($urandom_range(0, 3) == 0);
      ev        = 4'($urandom);
      rd_sel    = 2'($urandom);
      rd_src    = 1'($urandom);
      tick();
    end

    rst = 1'b0; clear = 1'b0; snap_req = 1'b0; ev = 4'b0000;
    tick(); tick();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised event-statistics bank for the pipelined CPU. It succeeds the fixed four-counter instruction statistics block.
- NUM_CH independent counters of CNT_W bits.
- Per-channel qualification: each channel is gated by either `enable` or `pc_enable`.
- Wrap or saturate mode, sticky overflow flags.
- Atomic snapshot via req/ack handshake, registered read-out mux for the display/IO path.
- Sits beside the pipeline controller. Inputs are raw per-cycle event strobes (cycle, jump, branch-taken, bubble, ...).

Parameters:
- NUM_CH, 4, number of event channels (1..16).
- CNT_W, 32, counter width in bits (8..64).
- SATURATE, 0, 0 = wrap at 2^CNT_W, 1 = hold at all-ones.
- PC_QUAL_MASK, 4'b0110, bit i = 1: channel i counts only when `pc_enable`=1; bit i = 0: channel i counts only when `enable`=1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  global run qualifier (CPU not halted)
- pc_enable  in  1  PC-advance qualifier
- clear  in  1  synchronous clear of counters and flags, same effect as rst on the counter state
- ev  in  NUM_CH  per-cycle event strobes, one bit per channel
- freeze  in  1  level; while 1 no counter increments
- snap_req  in  1  snapshot request
- snap_ack  out  1  one-cycle pulse when the shadow copy is valid
- rd_sel  in  $clog2(NUM_CH)  channel to read
- rd_src  in  1  0 = live counter, 1 = shadow copy
- rd_data  out  CNT_W  registered read data
- ovf  out  NUM_CH  sticky overflow flags
- irq  out  1  overflow interrupt (see Optional Feature)

Behaviour:
- Reset: on rst=1 at a clock edge, the following all go to 0:
  - every live counter and every shadow register;
  - ovf, rd_data, snap_ack, irq;
  - the FSM returns to IDLE.
- rst has priority over every other input.
- Increment condition for channel i, all terms true in the same cycle:
  - ev[i]=1;
  - freeze=0;
  - qualifier = PC_QUAL_MASK[i] ? pc_enable : enable.
- Increment size is +1 per qualifying cycle; the updated value is visible on the next cycle.
- Clear: clear=1 zeroes live counters and ovf in that cycle, overriding any increment.
  - Shadow registers are unaffected by clear.
  - Clear does not abort a snapshot in progress; the snapshot captures the post-clear zeros.
- Wrap mode (SATURATE=0): all-ones + 1 -> 0, and ovf[i] is set.
- Saturate mode (SATURATE=1): all-ones + 1 stays at all-ones, and ovf[i] is set.
- ovf[i] stays set until rst or clear.
- Snapshot FSM has two states, IDLE and CAPTURE.
  - IDLE, snap_req=1 -> CAPTURE.
  - CAPTURE: at the next edge, every shadow[i] takes live[i] as it stands after that edge's increment. snap_ack=1 for exactly one cycle. FSM returns to IDLE.
  - snap_req held high re-triggers every 2 cycles.
  - snap_req arriving while in CAPTURE is ignored.
- Snapshot latency: 2 cycles from snap_req sampled to snap_ack high. All channels are captured on the same edge, which makes the snapshot atomic.
- Read-out: rd_data is registered, with 1-cycle latency from rd_sel/rd_src.
  - rd_sel >= NUM_CH returns 0.
  - A live read shows the value as of the prior edge.
- Simultaneous increment and snapshot on the same edge: shadow holds the post-increment value.
- Reset during CAPTURE: the capture is lost and no snap_ack is issued.

Optional Feature:
- Macro: PERF_CNT_OVF_IRQ_EN.
- Defined: irq is a registered OR of (ovf & irq_mask), where irq_mask is an extra NUM_CH-wide input port present only under this macro. irq clears with ovf.
- Undefined: the irq_mask port is absent and irq is tied to 0.

Decomposition:
- Package perf_cnt_pkg holds:
  - channel index constants CH_CYCLE=0, CH_JMP=1, CH_BSUC=2, CH_BUBBLE=3;
  - default CNT_W;
  - snapshot FSM state encoding (IDLE=0, CAPTURE=1).
- Sub-module perf_cnt_cell: one counter with its qualifier, wrap/saturate logic and sticky ovf; instantiated NUM_CH times in a generate loop.
- The bank keeps the FSM, the shadow registers and the read mux.

Test Plan:
- Channel count and qualifier routing: rst 2 cycles, then enable=1, pc_enable=0, ev=4'b1111 for 10 cycles -> ch0=10, ch3=10, ch1=0, ch2=0 (default mask); rd_data matches each one cycle after rd_sel.
- Freeze: freeze=1 for 5 of 12 event cycles -> counter reads 7; clear pulse -> all counters 0, shadows unchanged.
- Wrap: CNT_W=8, SATURATE=0, 257 events -> value 1, ovf[i]=1. Saturate: same stimulus with SATURATE=1 -> value 255, ovf[i]=1.
- Snapshot atomicity: continuous events on all channels, snap_req at cycle 20 -> snap_ack at cycle 22; every shadow equals its live value at the capture edge; subsequent rd_src=1 reads stay constant while live counts keep rising.
- Reset mid-operation: rst asserted in the CAPTURE cycle -> no snap_ack, all outputs 0 the next cycle, counting resumes from 0.
- With PERF_CNT_OVF_IRQ_EN: irq_mask=4'b0001, overflow ch1 -> irq stays 0; overflow ch0 -> irq=1 one cycle later, cleared by clear.
